// File: rtl/hilo_pkg.sv
// Shared op codes, FSM states and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_FIX
  } state_e;

  localparam int unsigned HILO_W = 32;
  localparam logic [HILO_W-1:0] DIV_BY_ZERO_LO = '1;

endpackage

// File: rtl/restoring_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module restoring_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Compare at WIDTH+1 bits: the shifted partial remainder can exceed any WIDTH-bit divisor.
  assign shifted = {rem_i, dvd_msb_i};
  assign trial   = shifted - {1'b0, dsr_i};
  assign q_o     = (shifted >= {1'b0, dsr_i});
  assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with single-cycle multiply and iterative restoring divide.
// Define MULDIV_EARLY_OUT_EN to skip leading-zero dividend bits and shorten divides.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  state_e               state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 dbz_q, dbz_d;

  logic [2*WIDTH-1:0]   prod_s, prod_u;
  logic                 div_signed, dvd_neg, dsr_neg;
  logic [WIDTH-1:0]     dvd_abs, dsr_abs, dvd_init;
  logic [DIV_CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_bit;

  assign prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
  assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  assign div_signed = (op == DIV);
  assign dvd_neg    = div_signed & rs_data[WIDTH-1];
  assign dsr_neg    = div_signed & rt_data[WIDTH-1];
  assign dvd_abs    = dvd_neg ? -rs_data : rs_data;
  assign dsr_abs    = dsr_neg ? -rt_data : rt_data;

`ifdef MULDIV_EARLY_OUT_EN
  logic [DIV_CNT_W-1:0] lzc;

  always_comb begin
    lzc = DIV_CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (dvd_abs[i]) lzc = DIV_CNT_W'(WIDTH - 1 - i);
    end
  end

  // Leading zeros contribute only zero quotient bits, so they are shifted out up front.
  assign dvd_init = dvd_abs << lzc;
  assign cnt_init = (lzc == DIV_CNT_W'(WIDTH)) ? DIV_CNT_W'(1) : DIV_CNT_W'(WIDTH) - lzc;
`else
  assign dvd_init = dvd_abs;
  assign cnt_init = DIV_CNT_W'(WIDTH);
`endif

  restoring_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;

    case (state_q)
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DIV_CNT_W'(1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        hi_d    = rem_neg_q ? -rem_q : rem_q;
        lo_d    = dbz_q ? DIV_BY_ZERO_LO : (quo_neg_q ? -quo_q : quo_q);
        state_d = IDLE;
      end
      default: ;
    endcase

    // A new op always wins, including over a divide finishing on this same edge.
    if (start) begin
      case (op)
        MULT, MULTU: begin
          {hi_d, lo_d} = (op == MULT) ? prod_s : prod_u;
          state_d      = IDLE;
        end
        MTHI: begin
          hi_d    = rs_data;
          lo_d    = lo_q;
          state_d = IDLE;
        end
        MTLO: begin
          hi_d    = hi_q;
          lo_d    = rs_data;
          state_d = IDLE;
        end
        DIV, DIVU: begin
          hi_d      = hi_q;
          lo_d      = lo_q;
          dvd_d     = dvd_init;
          dsr_d     = dsr_abs;
          rem_d     = '0;
          quo_d     = '0;
          quo_neg_d = dvd_neg ^ dsr_neg;
          rem_neg_d = dvd_neg;
          dbz_d     = (rt_data == '0);
          cnt_d     = cnt_init;
          state_d   = DIV_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & hilo_read;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus queues timed expectations, a negedge monitor checks them.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic [2:0]  op        = 3'd0;
  logic [31:0] rs        = '0;
  logic [31:0] rt        = '0;
  logic        hilo_read = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall;

  hilo_muldiv_unit #(.WIDTH(32), .DIV_CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_data   (rs),
    .rt_data   (rt),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
  } exp_t;

  exp_t        sb[$];
  exp_t        item;
  exp_t        leftover;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] curHi  = '0;
  logic [31:0] curLo  = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, req, cyc);
  endtask

  // Entries are pushed in due order, so only the head ever needs inspecting.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      item = sb.pop_front();
      if (item.due < cyc) begin
        checks++;
        $display("[TB] FAIL %s: sampled at cycle %0d, expected at cycle %0d", item.name, cyc, item.due);
      end else begin
        checkOutput({item.name, "_hilo"}, {hi, lo}, {item.hi, item.lo});
        checkOutput({item.name, "_ctl"}, {62'd0, busy, stall}, {62'd0, item.busy, item.stall});
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectAt(input int due, input string name, input logic [31:0] h, input logic [31:0] l,
                          input logic b, input logic s);
    exp_t e;
    e.due = due; e.name = name; e.hi = h; e.lo = l; e.busy = b; e.stall = s;
    sb.push_back(e);
  endtask

  // Drives one start pulse; the start edge is the next posedge, and the task returns just after it.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs = a; rt = b; start = 1'b1;
    waitCycles(1);
    start = 1'b0;
  endtask

  task automatic runSingle(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    expectAt(cyc + 1, name, eh, el, 1'b0, 1'b0);
    applyStimulus(o, a, b);
    curHi = eh; curLo = el;
    waitCycles(1);
  endtask

  task automatic runDiv(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = cyc + 1;
    expectAt(n,      {name, "_start"}, curHi, curLo, 1'b1, hilo_read);
    expectAt(n + 32, {name, "_hold"},  curHi, curLo, 1'b1, hilo_read);
    expectAt(n + 33, name,             eh,    el,    1'b0, 1'b0);
    applyStimulus(o, a, b);
    waitCycles(33);
    curHi = eh; curLo = el;
    waitCycles(1);
  endtask

  initial begin
    int n;
    int m;
    waitCycles(2);
    reset = 1'b0;
    expectAt(cyc + 1, "reset", 32'h0, 32'h0, 1'b0, 1'b0);
    waitCycles(2);

    runSingle("mult_neg", MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runDiv("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runDiv("divu_big_2", DIVU, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 32'h7FFF_FFFC);
    runDiv("divu_by_zero", DIVU, 32'd100, 32'h0, 32'd100, 32'hFFFF_FFFF);
    runDiv("div_overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    hilo_read = 1'b1;
    runDiv("stall_divu_50_7", DIVU, 32'd50, 32'd7, 32'd1, 32'd7);
    hilo_read = 1'b0;

    // MTHI lands on cycle 10 of a divide and must cancel it.
    n = cyc + 1;
    expectAt(n + 5, "mthi_div_run", curHi, curLo, 1'b1, 1'b0);
    applyStimulus(DIVU, 32'd1000, 32'd3);
    waitCycles(9);
    m = cyc + 1;
    expectAt(m,      "mthi_abort",         32'h0000_ABCD, curLo, 1'b0, 1'b0);
    expectAt(m + 25, "mthi_no_late_write", 32'h0000_ABCD, curLo, 1'b0, 1'b0);
    applyStimulus(MTHI, 32'h0000_ABCD, 32'h0);
    curHi = 32'h0000_ABCD;
    waitCycles(26);

    runSingle("mtlo", MTLO, 32'h0000_1234, 32'h0, curHi, 32'h0000_1234);

    // One-cycle reset on cycle 15 of a divide.
    n = cyc + 1;
    expectAt(n + 14, "rst_div_run",       curHi, curLo, 1'b1, 1'b0);
    expectAt(n + 15, "rst_mid_div",       32'h0, 32'h0, 1'b0, 1'b0);
    expectAt(n + 40, "rst_no_late_write", 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(DIVU, 32'd50, 32'd7);
    waitCycles(14);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    curHi = '0; curLo = '0;
    waitCycles(26);

    runSingle("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // A second divide issued mid-flight restarts with full latency.
    n = cyc + 1;
    m = n + 5;
    expectAt(n + 33, "restart_old_suppressed", curHi, curLo, 1'b1, 1'b0);
    expectAt(m + 33, "restart_divu_200_9",     32'd2, 32'd22, 1'b0, 1'b0);
    applyStimulus(DIVU, 32'd100, 32'd7);
    waitCycles(4);
    applyStimulus(DIVU, 32'd200, 32'd9);
    waitCycles(34);
    curHi = 32'd2; curLo = 32'd22;

    runDiv("div_7_neg2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    runDiv("div_neg8_neg3", DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2);
    runDiv("div_neg5_zero", DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MULT issued during a divide replaces it outright.
    n = cyc + 1;
    m = n + 3;
    expectAt(m,      "mult_abort",      32'd1, 32'd0, 1'b0, 1'b0);
    expectAt(m + 35, "mult_abort_hold", 32'd1, 32'd0, 1'b0, 1'b0);
    applyStimulus(DIVU, 32'd77, 32'd5);
    waitCycles(2);
    applyStimulus(MULT, 32'h0001_0000, 32'h0001_0000);
    waitCycles(36);

    for (int i = 0; i < 200 && sb.size() > 0; i++) waitCycles(1);
    while (sb.size() > 0) begin
      leftover = sb.pop_front();
      checks++;
      $display("[TB] FAIL %s: never sampled, expected at cycle %0d", leftover.name, leftover.due);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
